// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - 16-bit instruction decoder with two-entry skid buffer
//
// Purpose: decodes one instruction word per accepted handshake into register
// fields and control bits, and buffers up to two decoded entries (main output
// register plus skid register) in program order.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   in_valid / in_ready          upstream handshake (in_ready is a flop)
//   in_instr[15:0], in_pc[7:0]   instruction word and its address
//   flush                        drop every held entry and the offered word
//   illegal_count[7:0]           saturating count of accepted illegal words
//   out_valid / out_ready        downstream handshake
//   out_opcode, out_rd, out_rs, out_rt, out_imm, out_pc   decoded fields
//   out_reg_we .. out_illegal    decoded control bits
//
// Opcode map: 0 MOVIR, 1 MOVRR, 2 MOVMR, 3 MOVRM, 4 ADDRR, 5 ADDI,
//             6 SUBRR, 7 SUBI, 8 JZI, 9 JZR, A-E illegal, F NOP.

module instr_decoder (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [15:0] in_instr,
    input  logic [7:0] in_pc,
    input  logic       flush,
    output logic [7:0] illegal_count,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_opcode,
    output logic [3:0] out_rd,
    output logic [3:0] out_rs,
    output logic [3:0] out_rt,
    output logic [7:0] out_imm,
    output logic [7:0] out_pc,
    output logic       out_reg_we,
    output logic       out_mem_rd,
    output logic       out_mem_we,
    output logic       out_alu_sub,
    output logic       out_use_imm,
    output logic       out_jump,
    output logic       out_jump_reg,
    output logic       out_illegal
);

    localparam logic [3:0] OP_MOVIR = 4'h0;
    localparam logic [3:0] OP_MOVRR = 4'h1;
    localparam logic [3:0] OP_MOVMR = 4'h2;
    localparam logic [3:0] OP_MOVRM = 4'h3;
    localparam logic [3:0] OP_ADDRR = 4'h4;
    localparam logic [3:0] OP_ADDI  = 4'h5;
    localparam logic [3:0] OP_SUBRR = 4'h6;
    localparam logic [3:0] OP_SUBI  = 4'h7;
    localparam logic [3:0] OP_JZI   = 4'h8;
    localparam logic [3:0] OP_JZR   = 4'h9;
    localparam logic [3:0] OP_NOP   = 4'hF;

    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] rd;
        logic [3:0] rs;
        logic [3:0] rt;
        logic [7:0] imm;
        logic [7:0] pc;
        logic       reg_we;
        logic       mem_rd;
        logic       mem_we;
        logic       alu_sub;
        logic       use_imm;
        logic       jump;
        logic       jump_reg;
        logic       illegal;
    } entry_t;

    entry_t     dec;
    entry_t     main_q, main_d;
    entry_t     skid_q, skid_d;
    logic       main_valid_q, main_valid_d;
    logic       skid_valid_q, skid_valid_d;
    logic       in_ready_q;
    logic [7:0] illegal_count_q;
    logic       accept;
    logic       xfer;

    logic [3:0] op;
    logic [3:0] fa;
    logic [3:0] fb;
    logic [3:0] fc;
    logic [7:0] imm;

    assign op  = in_instr[15:12];
    assign fa  = in_instr[11:8];
    assign fb  = in_instr[7:4];
    assign fc  = in_instr[3:0];
    assign imm = in_instr[7:0];

    assign accept = in_valid && in_ready_q && !flush;
    assign xfer   = main_valid_q && out_ready;

    // Decode: every field starts at zero so unused fields leave as zero.
    always_comb begin
        dec        = '0;
        dec.opcode = op;
        dec.pc     = in_pc;
        case (op)
            OP_MOVIR: begin
                dec.rd      = fa;
                dec.imm     = imm;
                dec.reg_we  = 1'b1;
                dec.use_imm = 1'b1;
            end
            OP_MOVRR: begin
                dec.rd     = fa;
                dec.rs     = fb;
                dec.reg_we = 1'b1;
            end
            OP_MOVMR: begin
                dec.rd      = fa;
                dec.imm     = imm;
                dec.reg_we  = 1'b1;
                dec.mem_rd  = 1'b1;
                dec.use_imm = 1'b1;
            end
            OP_MOVRM: begin
                dec.rs      = fa;
                dec.imm     = imm;
                dec.mem_we  = 1'b1;
                dec.use_imm = 1'b1;
            end
            OP_ADDRR, OP_SUBRR: begin
                dec.rd      = fa;
                dec.rs      = fb;
                dec.rt      = fc;
                dec.reg_we  = 1'b1;
                dec.alu_sub = (op == OP_SUBRR);
            end
            OP_ADDI, OP_SUBI: begin
                dec.rd      = fa;
                dec.rs      = fa;
                dec.imm     = imm;
                dec.reg_we  = 1'b1;
                dec.use_imm = 1'b1;
                dec.alu_sub = (op == OP_SUBI);
            end
            OP_JZI: begin
                dec.imm     = imm;
                dec.jump    = 1'b1;
                dec.use_imm = 1'b1;
            end
            OP_JZR: begin
                dec.rs       = fa;
                dec.jump     = 1'b1;
                dec.jump_reg = 1'b1;
            end
            OP_NOP: begin
                dec.reg_we = 1'b0;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

    // Buffer steering. in_ready mirrors "skid empty", so an accept can never
    // coincide with a full skid; the main register refills from the skid
    // first to keep program order.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_d       = '0;
            skid_d       = '0;
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || xfer) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            main_q          <= '0;
            skid_q          <= '0;
            main_valid_q    <= 1'b0;
            skid_valid_q    <= 1'b0;
            in_ready_q      <= 1'b1;
            illegal_count_q <= 8'h00;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= !skid_valid_d;
            // Flush does not touch the counter; a flushed offer is not accepted.
            if (accept && dec.illegal && (illegal_count_q != 8'hFF)) begin
                illegal_count_q <= illegal_count_q + 8'd1;
            end
        end
    end

    assign in_ready      = in_ready_q;
    assign illegal_count = illegal_count_q;
    assign out_valid     = main_valid_q;
    assign out_opcode    = main_q.opcode;
    assign out_rd        = main_q.rd;
    assign out_rs        = main_q.rs;
    assign out_rt        = main_q.rt;
    assign out_imm       = main_q.imm;
    assign out_pc        = main_q.pc;
    assign out_reg_we    = main_q.reg_we;
    assign out_mem_rd    = main_q.mem_rd;
    assign out_mem_we    = main_q.mem_we;
    assign out_alu_sub   = main_q.alu_sub;
    assign out_use_imm   = main_q.use_imm;
    assign out_jump      = main_q.jump;
    assign out_jump_reg  = main_q.jump_reg;
    assign out_illegal   = main_q.illegal;

endmodule

// File: tb/tb_instr_decoder.sv
// tb/tb_instr_decoder.sv - directed self-checking bench for instr_decoder

module tb_instr_decoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [7:0]  in_pc;
    logic        flush;
    logic [7:0]  illegal_count;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_opcode, out_rd, out_rs, out_rt;
    logic [7:0]  out_imm, out_pc;
    logic        out_reg_we, out_mem_rd, out_mem_we, out_alu_sub;
    logic        out_use_imm, out_jump, out_jump_reg, out_illegal;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    instr_decoder dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .flush        (flush),
        .illegal_count(illegal_count),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_opcode   (out_opcode),
        .out_rd       (out_rd),
        .out_rs       (out_rs),
        .out_rt       (out_rt),
        .out_imm      (out_imm),
        .out_pc       (out_pc),
        .out_reg_we   (out_reg_we),
        .out_mem_rd   (out_mem_rd),
        .out_mem_we   (out_mem_we),
        .out_alu_sub  (out_alu_sub),
        .out_use_imm  (out_use_imm),
        .out_jump     (out_jump),
        .out_jump_reg (out_jump_reg),
        .out_illegal  (out_illegal)
    );

    // {reg_we, mem_rd, mem_we, alu_sub, use_imm, jump, jump_reg, illegal}
    logic [7:0] ctrl;
    assign ctrl = {out_reg_we, out_mem_rd, out_mem_we, out_alu_sub,
                   out_use_imm, out_jump, out_jump_reg, out_illegal};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check the full decoded entry at the output.
    task automatic chk_entry(input string tag, input logic [3:0] op, input logic [3:0] rd,
                             input logic [3:0] rs, input logic [3:0] rt, input logic [7:0] imm,
                             input logic [7:0] pc, input logic [7:0] c);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".opcode"}, {28'd0, out_opcode}, {28'd0, op});
        chk({tag, ".rd"}, {28'd0, out_rd}, {28'd0, rd});
        chk({tag, ".rs"}, {28'd0, out_rs}, {28'd0, rs});
        chk({tag, ".rt"}, {28'd0, out_rt}, {28'd0, rt});
        chk({tag, ".imm"}, {24'd0, out_imm}, {24'd0, imm});
        chk({tag, ".pc"}, {24'd0, out_pc}, {24'd0, pc});
        chk({tag, ".ctrl"}, {24'd0, ctrl}, {24'd0, c});
    endtask

    // Single accept with out_ready=1, check the entry, then let it drain.
    task automatic one(input string tag, input logic [15:0] w, input logic [7:0] pc,
                       input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt,
                       input logic [7:0] imm, input logic [7:0] c);
        in_valid  = 1'b1;
        in_instr  = w;
        in_pc     = pc;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk_entry(tag, w[15:12], rd, rs, rt, imm, pc, c);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 16'h0000;
        in_pc     = 8'h00;
        flush     = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        chk("rst.valid", {31'd0, out_valid}, 32'd0);
        chk("rst.ready", {31'd0, in_ready}, 32'd1);
        chk("rst.cnt", {24'd0, illegal_count}, 32'd0);
        chk("rst.ctrl", {24'd0, ctrl}, 32'd0);
        chk("rst.fields", {out_opcode, out_rd, out_rs, out_rt, out_imm, out_pc}, 32'd0);

        // MOVIR
        one("movir", 16'h0A5C, 8'h10, 4'hA, 4'h0, 4'h0, 8'h5C, 8'b1000_1000);
        step();
        chk("movir.drain", {31'd0, out_valid}, 32'd0);

        // Stall: two entries fill main + skid
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 16'h4123;
        in_pc     = 8'h20;
        step();
        chk("stall.ready1", {31'd0, in_ready}, 32'd1);
        in_instr = 16'h6456;
        in_pc    = 8'h21;
        step();
        chk("stall.ready0", {31'd0, in_ready}, 32'd0);
        chk_entry("addrr", 4'h4, 4'h1, 4'h2, 4'h3, 8'h00, 8'h20, 8'b1000_0000);
        in_instr = 16'h0111;    // offered while not ready: must be ignored
        in_pc    = 8'h22;
        step();
        in_valid = 1'b0;
        chk_entry("addrr.hold", 4'h4, 4'h1, 4'h2, 4'h3, 8'h00, 8'h20, 8'b1000_0000);
        out_ready = 1'b1;
        step();
        chk("skid.ready_rise", {31'd0, in_ready}, 32'd1);
        chk_entry("subrr", 4'h6, 4'h4, 4'h5, 4'h6, 8'h00, 8'h21, 8'b1001_0000);
        step();
        chk("subrr.drain", {31'd0, out_valid}, 32'd0);

        // Illegal opcode: fields zero, only illegal set
        one("illegal", 16'hA5FF, 8'h30, 4'h0, 4'h0, 4'h0, 8'h00, 8'b0000_0001);
        chk("illegal.cnt", {24'd0, illegal_count}, 32'd1);

        // Remaining opcodes back to back
        one("movrm", 16'h3740, 8'h40, 4'h0, 4'h7, 4'h0, 8'h40, 8'b0010_1000);
        one("jzr",   16'h9500, 8'h41, 4'h0, 4'h5, 4'h0, 8'h00, 8'b0000_0110);
        one("movrr", 16'h1AB0, 8'h42, 4'hA, 4'hB, 4'h0, 8'h00, 8'b1000_0000);
        one("movmr", 16'h2B80, 8'h43, 4'hB, 4'h0, 4'h0, 8'h80, 8'b1100_1000);
        one("addi",  16'h5312, 8'h44, 4'h3, 4'h3, 4'h0, 8'h12, 8'b1000_1000);
        one("subi",  16'h7C34, 8'h45, 4'hC, 4'hC, 4'h0, 8'h34, 8'b1001_1000);
        one("jzi",   16'h80FF, 8'h46, 4'h0, 4'h0, 4'h0, 8'hFF, 8'b0000_1100);
        one("nop",   16'hF123, 8'h47, 4'h0, 4'h0, 4'h0, 8'h00, 8'b0000_0000);
        one("ill_e", 16'hE000, 8'h48, 4'h0, 4'h0, 4'h0, 8'h00, 8'b0000_0001);
        chk("ill_e.cnt", {24'd0, illegal_count}, 32'd2);
        step();

        // Flush with two entries held and an offer pending
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 16'h4123;
        step();
        in_instr = 16'h6456;
        step();
        in_instr = 16'hB000;
        flush    = 1'b1;
        out_ready = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush2.valid", {31'd0, out_valid}, 32'd0);
        chk("flush2.ready", {31'd0, in_ready}, 32'd1);
        chk("flush2.cnt", {24'd0, illegal_count}, 32'd2);

        // Flush with one entry held and an illegal word offered while ready
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 16'h0A5C;
        step();
        in_instr = 16'hC000;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush1.valid", {31'd0, out_valid}, 32'd0);
        chk("flush1.ready", {31'd0, in_ready}, 32'd1);
        chk("flush1.cnt", {24'd0, illegal_count}, 32'd2);
        step();
        chk("flush1.dropped", {31'd0, out_valid}, 32'd0);

        // Saturation: 300 illegal words
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 16'hD000;
        for (int i = 0; i < 252; i++) step();
        chk("sat.254", {24'd0, illegal_count}, 32'd254);
        step();
        chk("sat.255", {24'd0, illegal_count}, 32'd255);
        for (int i = 0; i < 47; i++) step();
        in_valid = 1'b0;
        chk("sat.hold", {24'd0, illegal_count}, 32'd255);
        chk("sat.last", {24'd0, ctrl}, 32'd1);
        step();

        // Reset mid-stream with an entry stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 16'h0A5C;
        step();
        in_valid  = 1'b0;
        reset_n   = 1'b0;
        out_ready = 1'b1;
        step();
        reset_n = 1'b1;
        chk("mrst.valid", {31'd0, out_valid}, 32'd0);
        chk("mrst.cnt", {24'd0, illegal_count}, 32'd0);
        chk("mrst.ready", {31'd0, in_ready}, 32'd1);
        chk("mrst.ctrl", {24'd0, ctrl}, 32'd0);
        step();
        chk("mrst.after", {31'd0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/instr_decoder.md
INSTR_DECODER -- requirements
Module: instr_decoder

Interface
REQ-001 The port list SHALL be, in order: clk in 1, rising-edge clock; reset_n in 1, synchronous active-low reset; the clock is the only clock.
REQ-002 The upstream ports SHALL be: in_valid in 1, instruction offered; in_ready out 1, decoder can accept; in_instr in 16, instruction word; in_pc in 8, address of the instruction.
REQ-003 The control ports SHALL be: flush in 1, discard all held instructions; illegal_count out 8, saturating count of accepted illegal instructions.
REQ-004 The downstream handshake ports SHALL be: out_valid out 1, decoded entry valid; out_ready in 1, consumer accepts.
REQ-005 The decoded field ports SHALL be: out_opcode out 4; out_rd out 4; out_rs out 4; out_rt out 4; out_imm out 8; out_pc out 8.
REQ-006 The decoded control ports SHALL be out_reg_we, out_mem_rd, out_mem_we, out_alu_sub, out_use_imm, out_jump, out_jump_reg and out_illegal, each out 1.

Function
REQ-007 The instruction format SHALL be: opcode = in_instr[15:12]; field A = [11:8]; field B = [7:4]; field C = [3:0]; imm = [7:0].
REQ-008 MOVIR SHALL decode to rd=A, imm, reg_we, use_imm.
REQ-009 MOVRR SHALL decode to rd=A, rs=B, reg_we.
REQ-010 MOVMR (load) SHALL decode to rd=A, imm as address, reg_we, mem_rd, use_imm.
REQ-011 MOVRM (store) SHALL decode to rs=A, imm as address, mem_we, use_imm.
REQ-012 ADDRR and SUBRR SHALL decode to rd=A, rs=B, rt=C, reg_we; SUBRR SHALL also assert alu_sub.
REQ-013 ADDI and SUBI SHALL decode to rd=A, rs=A, imm, reg_we, use_imm; SUBI SHALL also assert alu_sub.
REQ-014 JZI SHALL decode to imm as target, jump, use_imm.
REQ-015 JZR SHALL decode to rs=A, jump, jump_reg.
REQ-016 NOP SHALL decode to all control bits 0.
REQ-017 Opcodes 1010-1110 SHALL decode to out_illegal=1 with all other control bits 0.
REQ-018 Any field not used by the decoded opcode SHALL be output as 0.
REQ-019 out_opcode and out_pc SHALL always carry the raw opcode and the in_pc captured with the instruction.
REQ-020 The decoder SHALL hold two entries, a main output register and a skid register, and SHALL preserve program order.
REQ-021 Acceptance SHALL occur on a cycle with in_valid=1, in_ready=1 and flush=0.
REQ-022 Latency from acceptance to out_valid SHALL be 1 cycle.
REQ-023 in_ready SHALL be a registered signal equal to "skid register empty" and SHALL NOT depend combinationally on out_ready.
REQ-024 An output transfer SHALL occur on a cycle with out_valid=1 and out_ready=1.
REQ-025 While out_valid=1 and out_ready=0, all out_* fields SHALL remain stable.
REQ-026 If acceptance and a transfer occur in the same cycle with the skid register empty, the new entry SHALL go to the main register.
REQ-027 If acceptance occurs while the main register is stalled, the new entry SHALL go to the skid register.
REQ-028 On a transfer with the skid register full, the skid entry SHALL move to the main register and in_ready SHALL rise the next cycle.
REQ-029 A flush SHALL clear both entries at the next edge (out_valid=0, in_ready=1), and an instruction offered in the flush cycle SHALL be dropped.
REQ-030 A flush SHALL take priority over simultaneous acceptance and transfer.
REQ-031 illegal_count SHALL increment by 1 on each accepted illegal instruction, SHALL saturate at 255, and SHALL NOT be cleared by flush.
REQ-032 Outputs SHALL be registered, with no combinational path from in_* to out_*.

Reset
REQ-033 While reset_n=0 at a rising edge, the decoder SHALL clear both entries and illegal_count; out_valid, all out_* fields and all control bits SHALL be 0 and in_ready SHALL be 1 the following cycle.
REQ-034 A reset asserted mid-stream SHALL discard held entries with no transfer in that cycle.

Verification
REQ-035 Accept 0x0A5C (MOVIR, in_pc=0x10) with out_ready=1 -> next cycle out_valid=1, rd=0xA, imm=0x5C, reg_we=1, use_imm=1, rs=rt=0, out_pc=0x10.
REQ-036 Hold out_ready=0 and offer 0x4123 then 0x6456 -> both accepted, in_ready=0 afterwards, outputs stable; raise out_ready -> ADDRR (1,2,3) then SUBRR with alu_sub=1, in order; in_ready=1 one cycle after the first transfer.
REQ-037 Offer 0xA000 -> out_illegal=1, all control bits 0, illegal_count=1; after 300 illegal instructions -> illegal_count=255.
REQ-038 With two entries held, assert flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1, offered instruction never appears, illegal_count unchanged.
REQ-039 Offer 0x3740 (MOVRM) and then 0x9500 (JZR) -> first: rs=7, imm=0x40, mem_we=1, reg_we=0; second: rs=5, jump=1, jump_reg=1.
REQ-040 Drive reset_n=0 for one edge with an entry stalled -> out_valid=0, illegal_count=0, in_ready=1.
